// File: rtl/qpsk_pkg.sv
// Shared types and constellation tables for the QPSK framing transmitter.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // {I,Q} per phase index; entry n sits at bits [2n+1:2n]
  localparam logic [7:0] PHASE_IQ = {
    {SIGN_NEG, SIGN_POS},
    {SIGN_NEG, SIGN_NEG},
    {SIGN_POS, SIGN_NEG},
    {SIGN_POS, SIGN_POS}
  };

  function automatic logic [1:0] gray_map(input logic [1:0] dibit);
    logic [1:0] ph;
    case (dibit)
      2'b00:   ph = 2'd0;
      2'b01:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  function automatic logic [1:0] phase_iq(input logic [1:0] ph);
    return PHASE_IQ[{ph, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sym_rate_div.sv
// Symbol-rate divider: counts 0..DIV-1 and ticks on the last count of each period.
module sym_rate_div #(
  parameter int DIV = 50,
  localparam int CW = $clog2(DIV + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/qpsk_frame_tx.sv
// QPSK framing transmitter: preamble + payload serialised MSB-first into dibits,
// one Gray-mapped (optionally differential) I/Q symbol every SYM_DIV clocks.
module qpsk_frame_tx #(
  parameter int DATA_W = 40,
  parameter int PRE_W = 16,
  parameter logic [((PRE_W > 0) ? PRE_W : 1)-1:0] PREAMBLE = 16'hE4E4,
  parameter int SYM_DIV = 50,
  parameter bit DIFF_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] para_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sym_i,
  output logic              sym_q,
  output logic              sym_valid,
  output logic              frame_active,
  output logic              frame_done
);

  import qpsk_pkg::*;

  localparam int FW  = PRE_W + DATA_W;
  localparam int N   = FW / 2;
  localparam int SCW = $clog2(N + 1);
  localparam int DCW = $clog2(SYM_DIV + 1);
  localparam logic [SCW-1:0] N_SYM   = SCW'(N);
  localparam logic [DCW-1:0] DIV_PRE = (SYM_DIV > 1) ? DCW'(SYM_DIV - 2) : '0;
  localparam bit ONE_CYCLE = (N * SYM_DIV == 1);

  state_t          state, state_nxt;
  logic [FW-1:0]   frame_word;
  logic [FW-1:0]   shreg;
  logic [SCW-1:0]  sym_cnt;
  logic [SCW-1:0]  popped_nxt;
  logic [1:0]      phase;
  logic [1:0]      base_ph;
  logic [1:0]      ph_new;
  logic [1:0]      dibit;
  logic [DCW-1:0]  div_cnt;
  logic            div_tick;
  logic            ready_arm;
  logic            accept;
  logic            send_pop;
  logic            any_pop;
  logic            end_tick;
  logic            last_sym;

  if (PRE_W > 0) begin : g_pre
    assign frame_word = {PREAMBLE[PRE_W-1:0], para_in};
  end else begin : g_nopre
    assign frame_word = para_in;
  end

  sym_rate_div #(
    .DIV (SYM_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .cnt  (div_cnt),
    .tick (div_tick)
  );

  assign accept   = in_valid & in_ready;
  assign send_pop = (state == SEND) && div_tick && (sym_cnt != N_SYM);
  assign any_pop  = accept | send_pop;

  // The frame ends one cycle before the final period's tick, so look one count ahead.
  assign end_tick   = (SYM_DIV == 1) || (div_cnt == DIV_PRE);
  assign popped_nxt = sym_cnt + SCW'(send_pop);
  assign last_sym   = (state == SEND) && end_tick && (popped_nxt == N_SYM);

  assign dibit   = accept ? frame_word[FW-1 -: 2] : shreg[FW-1 -: 2];
  assign base_ph = accept ? 2'd0 : phase;
  assign ph_new  = DIFF_EN ? (base_ph + gray_map(dibit)) : gray_map(dibit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ONE_CYCLE ? DONE : SEND;
      SEND:    if (last_sym) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == IDLE) && ready_arm;
    frame_active = (state != IDLE);
    frame_done   = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_arm <= 1'b0;
      sym_valid <= 1'b0;
      sym_i     <= 1'b0;
      sym_q     <= 1'b0;
      phase     <= 2'd0;
      sym_cnt   <= '0;
    end else begin
      ready_arm <= 1'b1;
      sym_valid <= any_pop;
      if (any_pop) begin
        phase          <= ph_new;
        {sym_i, sym_q} <= phase_iq(ph_new);
        sym_cnt        <= accept ? SCW'(1) : popped_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= frame_word << 2;
    end else if (send_pop) begin
      shreg <= shreg << 2;
    end
  end

endmodule
